rf_write_arbiter: RTL

- Owns the single write port of the 32x32 register file and shares it between two writers: the pipeline writeback stage and a multi-cycle unit (mult/div, load miss return).
- After reset, clears every register to zero before any other write is accepted.
- Suppresses writes to register 0.
- Guarantees forward progress for the multi-cycle unit with a starvation limit.
- Sits between the writeback/multi-cycle logic and the register file's regWrite/writeReg/writeData inputs.

---
 rtl/rf_write_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: clears all registers after reset, then shares the
// single write port between the writeback stage and a multi-cycle unit with a starvation guard.
module rf_write_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              md_req,
  input  logic [ADDR_W-1:0] md_reg,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_grant,
  output logic              init_busy,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData
);

  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] initIdx_q, initIdx_d;
  logic [CNT_W-1:0]  starveCnt_q, starveCnt_d;
  logic              regWrite_q, regWrite_d;
  logic [ADDR_W-1:0] writeReg_q, writeReg_d;
  logic [DATA_W-1:0] writeData_q, writeData_d;

  logic mdForce;
  logic wbEff;
  logic selWb;
  logic selMd;
  logic initBusy;
  logic wbStall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && initIdx_q == LAST_IDX) begin
      state_d = RUN;
    end
  end

  // Arbitration: a starved md request beats writeback; a writeback to r0 is swallowed
  // here so it never blocks the port.
  always_comb begin
    initBusy = 1'b0;
    wbStall  = 1'b0;
    selWb    = 1'b0;
    selMd    = 1'b0;
    mdForce  = 1'b0;
    wbEff    = 1'b0;
    if (state_q == INIT) begin
      initBusy = 1'b1;
      wbStall  = 1'b1;
    end else begin
      mdForce = md_req && (starveCnt_q == LIMIT);
      wbEff   = wb_valid && (wb_reg != '0);
      if (mdForce) begin
        selMd   = 1'b1;
        wbStall = 1'b1;
      end else if (wbEff) begin
        selWb = 1'b1;
      end else if (md_req) begin
        selMd = 1'b1;
      end
    end
  end

  assign init_busy = initBusy;
  assign wb_stall  = wbStall;
  assign md_grant  = selMd;

  always_comb begin
    regWrite_d  = 1'b0;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    initIdx_d   = initIdx_q;
    starveCnt_d = starveCnt_q;
    if (state_q == INIT) begin
      regWrite_d  = 1'b1;
      writeReg_d  = initIdx_q;
      writeData_d = '0;
      initIdx_d   = initIdx_q + 1'b1;
      starveCnt_d = '0;
    end else begin
      if (selWb) begin
        regWrite_d  = 1'b1;
        writeReg_d  = wb_reg;
        writeData_d = wb_data;
      end else if (selMd) begin
        regWrite_d  = (md_reg != '0);
        writeReg_d  = md_reg;
        writeData_d = md_data;
      end
      // Counts only consecutive denied cycles; any grant or idle md restarts it.
      if (md_req && !selMd) begin
        starveCnt_d = (starveCnt_q == LIMIT) ? LIMIT : starveCnt_q + 1'b1;
      end else begin
        starveCnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      initIdx_q   <= '0;
      starveCnt_q <= '0;
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
    end else begin
      initIdx_q   <= initIdx_d;
      starveCnt_q <= starveCnt_d;
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
    end
  end

  assign regWrite  = regWrite_q;
  assign writeReg  = writeReg_q;
  assign writeData = writeData_q;

endmodule
